// File: rtl/router_reg_p.sv
// router_reg_p: router data/parity register stage.
// Latches the packet header, forwards header and payload to the output FIFO,
// holds one word while the FIFO is full, verifies the trailing check word
// (XOR parity or additive checksum) and cross-checks the payload count
// against the header length field.
module router_reg_p #(
   parameter int unsigned DW        = 8,
   parameter int unsigned ADDR_W    = 2,
   parameter int unsigned MODE      = 0,
   parameter int unsigned LEN_CHECK = 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              lfd_state,
   input  logic              rst_int_reg,
   input  logic [DW-1:0]     data_in,
   output logic [DW-1:0]     dout,
   output logic              err,
   output logic              parity_done,
   output logic              low_packet_valid,
   output logic              len_err,
   output logic [ADDR_W-1:0] hdr_addr
);

   // Length field occupies the header bits above the address; the payload
   // counter is one bit wider so an over-long packet still reads as a mismatch.
   localparam int unsigned LW = DW - ADDR_W;
   localparam int unsigned CW = LW + 1;

   localparam logic [ADDR_W-1:0] ADDR_RSVD = '1;
   localparam logic [CW-1:0]     CNT_MAX   = '1;

   logic [DW-1:0] hdr_reg;
   logic [DW-1:0] hold_reg;
   logic [DW-1:0] acc;
   logic [DW-1:0] chk_reg;
   logic [CW-1:0] count;
   logic          pd_q;

   logic          hdr_load;
   logic          payload_en;
   logic          capture;
   logic          eval;
   logic          len_mismatch;

   // Check function: XOR parity or sum modulo 2^DW
   function automatic logic [DW-1:0] fold(input logic [DW-1:0] a,
                                          input logic [DW-1:0] x);
      logic [DW-1:0] r;
      if (MODE == 1) r = a + x;
      else           r = a ^ x;
      return r;
   endfunction

   // Decode of the per-cycle enables shared by several registers
   always_comb begin
      hdr_load     = detect_add & pkt_valid & (data_in[ADDR_W-1:0] != ADDR_RSVD);
      payload_en   = ld_state & pkt_valid & ~full_state;
      capture      = (ld_state & ~fifo_full & ~pkt_valid)
                   | (laf_state & low_packet_valid & ~parity_done);
      // first cycle with parity_done high: the check word is now in chk_reg
      eval         = parity_done & ~pd_q;
      len_mismatch = (count != {1'b0, hdr_reg[DW-1:ADDR_W]});
   end

   // Header register; a reserved destination address leaves it untouched
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hdr_reg <= '0;
      end else if (hdr_load) begin
         hdr_reg <= data_in;
      end
   end

   // Output word select; a word arriving while the FIFO is full is parked
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dout     <= '0;
         hold_reg <= '0;
      end else if (lfd_state) begin
         dout <= hdr_reg;
      end else if (ld_state && !fifo_full) begin
         dout <= data_in;
      end else if (ld_state && fifo_full) begin
         hold_reg <= data_in;
      end else if (laf_state) begin
         dout <= hold_reg;
      end
   end

   // Running check accumulator and saturating payload counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc   <= '0;
         count <= '0;
      end else if (detect_add) begin
         acc   <= '0;
         count <= '0;
      end else if (lfd_state) begin
         acc <= fold(acc, hdr_reg);
      end else if (payload_en) begin
         acc <= fold(acc, data_in);
         if (count != CNT_MAX) count <= count + 1'b1;
      end
   end

   // Check word capture and parity_done flag
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         chk_reg     <= '0;
         parity_done <= 1'b0;
         pd_q        <= 1'b0;
      end else begin
         pd_q <= parity_done;
         if (capture) chk_reg <= data_in;
         if (detect_add)   parity_done <= 1'b0;
         else if (capture) parity_done <= 1'b1;
      end
   end

   // low_packet_valid: pkt_valid dropped during load; rst_int_reg wins
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         low_packet_valid <= 1'b0;
      end else if (rst_int_reg) begin
         low_packet_valid <= 1'b0;
      end else if (ld_state && !pkt_valid) begin
         low_packet_valid <= 1'b1;
      end
   end

   // Sticky error flags, evaluated once per packet after the check capture
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err     <= 1'b0;
         len_err <= 1'b0;
      end else if (detect_add) begin
         err     <= 1'b0;
         len_err <= 1'b0;
      end else if (eval) begin
         err     <= (acc != chk_reg);
         len_err <= (LEN_CHECK != 0) && len_mismatch;
      end
   end

   assign hdr_addr = hdr_reg[ADDR_W-1:0];

endmodule

// File: tb/tb_router_reg_p.sv
// tb_router_reg_p: self-checking bench for router_reg_p. Two instances share
// stimulus: u0 in XOR mode with length checking, u1 in sum mode without it.
// A packet-level model (list of folded words, payload count) supplies the
// expected outputs every cycle; directed cases pin the model with literals.
module tb_router_reg_p;

   localparam int S_IDLE = 0;
   localparam int S_DA   = 1;
   localparam int S_LFD  = 2;
   localparam int S_LD   = 3;
   localparam int S_LAF  = 4;
   localparam int S_FS   = 5;

   logic       clock;
   logic       resetn;
   logic       pkt_valid, fifo_full, detect_add, ld_state, laf_state;
   logic       full_state, lfd_state, rst_int_reg;
   logic [7:0] data_in;

   logic [7:0] dout0, dout1;
   logic       err0, err1, pd0, pd1, lpv0, lpv1, len0, len1;
   logic [1:0] ha0, ha1;

   int         n_cmp = 0;
   int         n_bad = 0;
   bit         chk_en = 1'b0;

   router_reg_p #(.DW(8), .ADDR_W(2), .MODE(0), .LEN_CHECK(1)) u0 (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
      .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
      .data_in(data_in), .dout(dout0), .err(err0), .parity_done(pd0),
      .low_packet_valid(lpv0), .len_err(len0), .hdr_addr(ha0));

   router_reg_p #(.DW(8), .ADDR_W(2), .MODE(1), .LEN_CHECK(0)) u1 (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
      .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
      .data_in(data_in), .dout(dout1), .err(err1), .parity_done(pd1),
      .low_packet_valid(lpv1), .len_err(len1), .hdr_addr(ha1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- comparison helper ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_hdr, m_dout, m_hold, m_chk;
   logic [7:0] m_f[$];        // every word folded into the check since detect_add
   int         m_cnt;         // payload words folded, saturating at 127
   logic       m_pd, m_lpv, m_ex, m_es, m_len;
   int         m_age;         // cycles parity_done has been high

   function automatic logic [7:0] f_xor();
      logic [7:0] a = '0;
      foreach (m_f[i]) a = a ^ m_f[i];
      return a;
   endfunction

   function automatic logic [7:0] f_sum();
      logic [7:0] a = '0;
      foreach (m_f[i]) a = a + m_f[i];
      return a;
   endfunction

   task automatic model_clear();
      m_hdr = '0; m_dout = '0; m_hold = '0; m_chk = '0;
      m_f.delete(); m_cnt = 0; m_age = 0;
      m_pd = 1'b0; m_lpv = 1'b0; m_ex = 1'b0; m_es = 1'b0; m_len = 1'b0;
   endtask

   task automatic model_step();
      logic c, ev;
      c  = (ld_state && !fifo_full && !pkt_valid) || (laf_state && m_lpv && !m_pd);
      ev = m_pd && (m_age == 0);
      if (detect_add) begin
         m_ex = 1'b0; m_es = 1'b0; m_len = 1'b0;
      end else if (ev) begin
         m_ex  = (f_xor() != m_chk);
         m_es  = (f_sum() != m_chk);
         m_len = (m_cnt != int'({26'd0, m_hdr[7:2]}));
      end
      m_age = m_pd ? ((m_age < 1000) ? m_age + 1 : m_age) : 0;
      if (lfd_state)                    m_dout = m_hdr;
      else if (ld_state && !fifo_full)  m_dout = data_in;
      else if (ld_state && fifo_full)   m_hold = data_in;
      else if (laf_state)               m_dout = m_hold;
      if (detect_add) begin
         m_f.delete(); m_cnt = 0;
      end else if (lfd_state) begin
         m_f.push_back(m_hdr);
      end else if (ld_state && pkt_valid && !full_state) begin
         m_f.push_back(data_in);
         if (m_cnt < 127) m_cnt++;
      end
      if (c) m_chk = data_in;
      if (detect_add) m_pd = 1'b0;
      else if (c)     m_pd = 1'b1;
      if (rst_int_reg)                   m_lpv = 1'b0;
      else if (ld_state && !pkt_valid)   m_lpv = 1'b1;
      if (detect_add && pkt_valid && data_in[1:0] != 2'b11) m_hdr = data_in;
   endtask

   initial model_clear();
   always @(posedge clock) begin
      if (!resetn) model_clear();
      else         model_step();
   end
   always @(negedge resetn) model_clear();

   // Every-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en) begin
         chk("u0.dout", 32'(dout0), 32'(m_dout));
         chk("u0.err", 32'(err0), 32'(m_ex));
         chk("u0.parity_done", 32'(pd0), 32'(m_pd));
         chk("u0.low_packet_valid", 32'(lpv0), 32'(m_lpv));
         chk("u0.len_err", 32'(len0), 32'(m_len));
         chk("u0.hdr_addr", 32'(ha0), 32'(m_hdr[1:0]));
         chk("u1.dout", 32'(dout1), 32'(m_dout));
         chk("u1.err", 32'(err1), 32'(m_es));
         chk("u1.parity_done", 32'(pd1), 32'(m_pd));
         chk("u1.low_packet_valid", 32'(lpv1), 32'(m_lpv));
         chk("u1.len_err", 32'(len1), 32'd0);
         chk("u1.hdr_addr", 32'(ha1), 32'(m_hdr[1:0]));
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] pl[$];

   // Apply one cycle of inputs; returns one half-cycle after the edge so the
   // outputs reflect this cycle and the next inputs can be applied.
   task automatic step(input int s, input logic ff, input logic pv,
                       input logic rir, input logic [7:0] d);
      detect_add  = (s == S_DA);
      lfd_state   = (s == S_LFD);
      ld_state    = (s == S_LD);
      laf_state   = (s == S_LAF);
      full_state  = (s == S_FS);
      fifo_full   = ff;
      pkt_valid   = pv;
      rst_int_reg = rir;
      data_in     = d;
      @(negedge clock);
      #1;
   endtask

   // Header, payload from pl, check word; ends right after the capture edge
   task automatic send_pkt(input logic [7:0] h, input logic [7:0] c, input bit stall_en);
      bit st;
      step(S_DA, 1'b0, 1'b1, 1'b0, h);
      step(S_LFD, 1'b0, 1'b1, 1'b0, h);
      foreach (pl[i]) begin
         st = stall_en && ($urandom_range(0, 3) == 0);
         if (st) begin
            step(S_LD, 1'b1, 1'b1, 1'b0, pl[i]);
            step(S_FS, 1'b1, 1'b1, 1'b0, pl[i]);
            step(S_LAF, 1'b0, 1'b1, 1'b0, pl[i]);
         end else begin
            step(S_LD, 1'b0, 1'b1, 1'b0, pl[i]);
         end
      end
      st = stall_en && ($urandom_range(0, 2) == 0);
      if (st) begin
         step(S_LD, 1'b1, 1'b0, 1'b0, c);
         step(S_FS, 1'b1, 1'b0, 1'b0, c);
         step(S_LAF, 1'b0, 1'b0, 1'b0, c);
      end else begin
         step(S_LD, 1'b0, 1'b0, 1'b0, c);
      end
   endtask

   task automatic idle(input logic rir);
      step(S_IDLE, 1'b0, 1'b0, rir, 8'h00);
   endtask

   task automatic set_pl3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      pl.delete();
      pl.push_back(a); pl.push_back(b); pl.push_back(c);
   endtask

   // Watchdog: the run is clock-bounded, this only guards against a hang
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] h, c, x, s;
      int         n, len;
      resetn = 1'b1;
      pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; ld_state = 1'b0;
      laf_state = 1'b0; full_state = 1'b0; lfd_state = 1'b0; rst_int_reg = 1'b0;
      data_in = 8'h00;
      #2 resetn = 1'b0;
      repeat (2) @(negedge clock);
      #1 resetn = 1'b1;
      chk_en = 1'b1;
      chk("reset.dout", 32'(dout0), 32'h0);
      chk("reset.parity_done", 32'(pd0), 32'h0);
      chk("reset.hdr_addr", 32'(ha0), 32'h0);

      // Packet 1: header 0x0D, payload 24 81 09, check A1
      step(S_DA, 1'b0, 1'b1, 1'b0, 8'h0D);
      chk("p1.hdr_addr", 32'(ha0), 32'h1);
      step(S_LFD, 1'b0, 1'b1, 1'b0, 8'h0D);
      chk("p1.dout0", 32'(dout0), 32'h0D);
      step(S_LD, 1'b0, 1'b1, 1'b0, 8'h24);
      chk("p1.dout1", 32'(dout0), 32'h24);
      step(S_LD, 1'b0, 1'b1, 1'b0, 8'h81);
      chk("p1.dout2", 32'(dout0), 32'h81);
      step(S_LD, 1'b0, 1'b1, 1'b0, 8'h09);
      chk("p1.dout3", 32'(dout0), 32'h09);
      step(S_LD, 1'b0, 1'b0, 1'b0, 8'hA1);
      chk("p1.parity_done", 32'(pd0), 32'h1);
      chk("p1.lpv", 32'(lpv0), 32'h1);
      idle(1'b1);
      chk("p1.err", 32'(err0), 32'h0);
      chk("p1.len_err", 32'(len0), 32'h0);
      chk("p1.sum_err", 32'(err1), 32'h1);
      chk("p1.lpv_clr", 32'(lpv0), 32'h0);

      // Packet 2: inverted check word
      set_pl3(8'h24, 8'h81, 8'h09);
      send_pkt(8'h0D, 8'h5E, 1'b0);
      chk("p2.err_pre", 32'(err1), 32'h0);
      idle(1'b1);
      chk("p2.err", 32'(err0), 32'h1);
      chk("p2.parity_done", 32'(pd0), 32'h1);
      chk("p2.len_err", 32'(len0), 32'h0);

      // Packet 3: additive check word
      send_pkt(8'h0D, 8'hBB, 1'b0);
      idle(1'b1);
      chk("p3.sum_err", 32'(err1), 32'h0);
      chk("p3.xor_err", 32'(err0), 32'h1);

      // Packet 4: header length 4, three payload words
      set_pl3(8'h01, 8'h02, 8'h03);
      send_pkt(8'h11, 8'h11, 1'b0);
      idle(1'b1);
      chk("p4.err", 32'(err0), 32'h0);
      chk("p4.len_err", 32'(len0), 32'h1);
      chk("p4.len_err_off", 32'(len1), 32'h0);

      // FIFO full hold, then rst_int_reg against low-packet set
      step(S_DA, 1'b0, 1'b1, 1'b0, 8'h0D);
      step(S_LFD, 1'b0, 1'b1, 1'b0, 8'h0D);
      step(S_LD, 1'b0, 1'b1, 1'b0, 8'h24);
      step(S_LD, 1'b1, 1'b1, 1'b0, 8'h55);
      chk("full.hold0", 32'(dout0), 32'h24);
      step(S_FS, 1'b1, 1'b1, 1'b0, 8'h55);
      chk("full.hold1", 32'(dout0), 32'h24);
      step(S_LAF, 1'b0, 1'b1, 1'b0, 8'h55);
      chk("full.laf", 32'(dout0), 32'h55);
      step(S_LD, 1'b0, 1'b0, 1'b1, 8'h7E);
      chk("full.rst_int_wins", 32'(lpv0), 32'h0);
      idle(1'b0);

      // Reserved address: header register unchanged
      step(S_DA, 1'b0, 1'b1, 1'b0, 8'h0F);
      chk("rsvd.hdr_addr", 32'(ha0), 32'h1);
      step(S_LFD, 1'b0, 1'b1, 1'b0, 8'h0F);
      chk("rsvd.dout", 32'(dout0), 32'h0D);
      idle(1'b1);

      // Asynchronous reset mid-payload, then a clean packet
      step(S_DA, 1'b0, 1'b1, 1'b0, 8'h0D);
      step(S_LFD, 1'b0, 1'b1, 1'b0, 8'h0D);
      step(S_LD, 1'b0, 1'b1, 1'b0, 8'h24);
      resetn = 1'b0;
      #1;
      chk("arst.dout", 32'(dout0), 32'h0);
      chk("arst.hdr_addr", 32'(ha0), 32'h0);
      chk("arst.err", 32'(err0), 32'h0);
      chk("arst.parity_done", 32'(pd0), 32'h0);
      chk("arst.lpv", 32'(lpv0), 32'h0);
      chk("arst.len_err", 32'(len0), 32'h0);
      chk("arst.u1_dout", 32'(dout1), 32'h0);
      idle(1'b0);
      resetn = 1'b1;
      idle(1'b0);
      set_pl3(8'h24, 8'h81, 8'h09);
      send_pkt(8'h0D, 8'hA1, 1'b0);
      idle(1'b1);
      chk("arst.next_err", 32'(err0), 32'h0);
      chk("arst.next_pd", 32'(pd0), 32'h1);

      // Counter saturation: 128 words against length 0
      pl.delete();
      x = 8'h00;
      for (int i = 0; i < 128; i++) begin
         pl.push_back(8'($urandom_range(0, 255)));
         x = x ^ pl[i];
      end
      send_pkt(8'h00, x, 1'b0);
      idle(1'b1);
      chk("sat.len_err", 32'(len0), 32'h1);
      chk("sat.err", 32'(err0), 32'h0);

      // Maximum length field exactly matched
      pl.delete();
      x = 8'hFC;
      for (int i = 0; i < 63; i++) begin
         pl.push_back(8'($urandom_range(0, 255)));
         x = x ^ pl[i];
      end
      send_pkt(8'hFC, x, 1'b1);
      idle(1'b1);
      chk("maxlen.len_err", 32'(len0), 32'h0);
      chk("maxlen.err", 32'(err0), 32'h0);

      // Random well-formed packets with FIFO stalls
      for (int k = 0; k < 30; k++) begin
         n = int'($urandom_range(0, 8));
         len = ($urandom_range(0, 1) == 1) ? n : int'($urandom_range(0, 63));
         h = {6'(len), 2'($urandom_range(0, 2))};
         pl.delete();
         x = h;
         s = h;
         for (int i = 0; i < n; i++) begin
            pl.push_back(8'($urandom_range(0, 255)));
            x = x ^ pl[i];
            s = s + pl[i];
         end
         case ($urandom_range(0, 2))
            0:       c = x;
            1:       c = s;
            default: c = 8'($urandom_range(0, 255));
         endcase
         send_pkt(h, c, 1'b1);
         idle(1'b0);
         idle(1'b1);
      end

      // Random strobe sequences (at most one FSM state active per cycle)
      for (int k = 0; k < 400; k++) begin
         step(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              8'($urandom_range(0, 255)));
      end
      idle(1'b1);
      idle(1'b0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
